// File: rtl/serial_shift_receiver_pkg.sv
// Shared definitions for the 4-bit shift datapath: FSM state encoding and default width.
// The matching transmitter imports the same package.
package serial_shift_receiver_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_shift_receiver_if.sv
// Serial-in / parallel-out bundle between the link driver, the receiver and its consumer.
interface serial_shift_receiver_if
    import serial_shift_receiver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             sin;
    logic             sin_valid;
    logic             sin_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic             ovr_clr;
    logic             busy;

    modport master (
        output sin, sin_valid, sin_start, dout_ready, ovr_clr,
        input  dout, dout_valid, overrun, busy
    );

    modport slave (
        input  sin, sin_valid, sin_start, dout_ready, ovr_clr,
        output dout, dout_valid, overrun, busy
    );
endinterface

// File: rtl/serial_shift_receiver_rx_shift_reg.sv
// Receive shift register; exposes its next-state value so the completing bit
// can be transferred on the same edge that samples it.
module rx_shift_reg
    import serial_shift_receiver_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             load_start,
    input  logic             sin,
    output logic [WIDTH-1:0] sh_next
);
    logic [WIDTH-1:0] sh_r;
    logic [WIDTH-1:0] sh_s;

    // Next shift value; a start bit discards whatever partial word was held
    always_comb begin
        sh_s = sh_r;
        if (shift_en && load_start) begin
            if (MSB_FIRST) begin
                sh_s = {{(WIDTH-1){1'b0}}, sin};
            end else begin
                sh_s = {sin, {(WIDTH-1){1'b0}}};
            end
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                sh_s = {sh_r[WIDTH-2:0], sin};
            end else begin
                sh_s = {sin, sh_r[WIDTH-1:1]};
            end
        end else begin
            sh_s = sh_r;
        end
    end

    // Shift register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r <= {WIDTH{1'b0}};
        end else begin
            sh_r <= sh_s;
        end
    end

    assign sh_next = sh_s;
endmodule

// File: rtl/serial_shift_receiver.sv
// Framed serial-in, parallel-out receiver: bit-count FSM, one-word hold register
// under valid/ready, and a sticky overrun flag for words dropped while the hold is full.
module serial_shift_receiver
    import serial_shift_receiver_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_shift_receiver_if.slave bus
);
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             busy_r;
    logic             shift_en_s;
    logic             load_start_s;
    logic             complete_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;
    logic             overrun_r;

    assign load_start_s = bus.sin_valid && bus.sin_start;
    assign shift_en_s   = bus.sin_valid && (bus.sin_start || (state_r == ST_SHIFT));

    rx_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en_s),
        .load_start (load_start_s),
        .sin        (bus.sin),
        .sh_next    (word_s)
    );

    // Next-state and bit-count logic; a start bit always restarts the count at 1
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        complete_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_start_s) begin
                    state_s = ST_SHIFT;
                    cnt_s   = CW'(1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (load_start_s) begin
                    cnt_s = CW'(1);
                end else if (bus.sin_valid && (cnt_r == LAST_CNT)) begin
                    complete_s = 1'b1;
                    cnt_s      = {CW{1'b0}};
                    state_s    = ST_IDLE;
                end else if (bus.sin_valid) begin
                    cnt_s = cnt_r + CW'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // FSM state, counter and busy flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == ST_SHIFT);
        end
    end

    // Hold register, handshake and sticky overrun; a drop outranks a same-edge clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (complete_s && (!dout_valid_r || bus.dout_ready)) begin
                dout_r       <= word_s;
                dout_valid_r <= 1'b1;
            end else if (dout_valid_r && bus.dout_ready) begin
                dout_valid_r <= 1'b0;
            end else begin
                dout_valid_r <= dout_valid_r;
            end

            if (complete_s && dout_valid_r && !bus.dout_ready) begin
                overrun_r <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.overrun    = overrun_r;
    assign bus.busy       = busy_r;
endmodule
